// File: rtl/control_id_sequencer_pkg.sv
// Shared constants, state encoding and ID classification for the ID sequencer
// and its neighbours in the front end.
package control_id_sequencer_pkg;

    localparam int ID_WIDTH = 7;

    typedef logic [ID_WIDTH-1:0] id_t;

    localparam id_t RESET_ID  = 7'd100;
    localparam id_t BUBBLE_ID = 7'd0;
    localparam id_t HALT_ID   = 7'd75;
    localparam id_t SWI_ID    = 7'd72;
    localparam id_t RETURN_ID = 7'd74;

    localparam id_t MEM_RANGE_LO = 7'd40;
    localparam id_t MEM_RANGE_HI = 7'd55;
    localparam id_t MEM_EXTRA_A  = 7'd67;
    localparam id_t MEM_EXTRA_B  = 7'd68;

    typedef enum logic [1:0] {
        ST_RST      = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } seq_state_e;

    function automatic logic is_memory_id(input id_t id);
        return ((id >= MEM_RANGE_LO) && (id <= MEM_RANGE_HI)) ||
               (id == MEM_EXTRA_A) || (id == MEM_EXTRA_B);
    endfunction

endpackage

// File: rtl/control_reset_timer.sv
// Counts RESET_CYCLES clock edges after reset release, then holds reset_done_o
// high until the next reset.
module control_reset_timer #(
    parameter int RESET_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic reset_done_o
);

    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(RESET_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign reset_done_o = (cnt_q == LIMIT);

endmodule

// File: rtl/control_id_sequencer.sv
// Issue stage in front of ControlCore: registers the instruction ID, plays the
// reset ID sequence, inserts bubbles, stalls on memory, halts, and owns MODE.
module control_id_sequencer
    import control_id_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ID_WIDTH-1:0]    decoded_id,
    input  logic                   decoded_valid,
    output logic                   fetch_ready,
    input  logic                   flush,
    input  logic                   mem_ready,
    input  logic                   resume,
    output logic [ID_WIDTH-1:0]    ID,
    output logic                   id_valid,
    output logic                   MODE,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] issued_count
);

    seq_state_e             state_q, state_d;
    id_t                    id_q, id_d;
    logic                   id_valid_q, id_valid_d;
    logic                   mode_q, mode_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   pending_flush_q, pending_flush_d;
    logic                   reset_done;
    logic                   accept;

    control_reset_timer #(
        .RESET_CYCLES (RESET_CYCLES)
    ) u_reset_timer (
        .clk_i        (clock),
        .rst_ni       (reset),
        .reset_done_o (reset_done)
    );

    // A flush remembered from MEM_WAIT blocks the first RUN cycle just like a live flush.
    assign fetch_ready = (state_q == ST_RUN) && !flush && !pending_flush_q;
    assign accept      = decoded_valid && fetch_ready;

    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        id_valid_d      = id_valid_q;
        mode_d          = mode_q;
        count_d         = count_q;
        pending_flush_d = pending_flush_q;

        // SWI raises MODE one cycle after it is registered so ControlCore sees the old mode first.
        if (id_valid_q && (id_q == SWI_ID)) begin
            mode_d = 1'b1;
        end

        unique case (state_q)
            ST_RST: begin
                id_d       = RESET_ID;
                id_valid_d = 1'b0;
                if (reset_done) begin
                    id_d    = BUBBLE_ID;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pending_flush_d = 1'b0;
                if (accept) begin
                    id_d       = decoded_id;
                    id_valid_d = 1'b1;
                    count_d    = count_q + COUNT_WIDTH'(1);
                    if (decoded_id == RETURN_ID) begin
                        mode_d = 1'b0;
                    end
                    if (is_memory_id(decoded_id)) begin
                        state_d = ST_MEM_WAIT;
                    end else if (decoded_id == HALT_ID) begin
                        state_d = ST_HALT;
                    end
                end else begin
                    id_d       = BUBBLE_ID;
                    id_valid_d = 1'b0;
                end
            end
            ST_MEM_WAIT: begin
                if (flush) begin
                    pending_flush_d = 1'b1;
                end
                if (mem_ready) begin
                    id_d       = BUBBLE_ID;
                    id_valid_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_HALT: begin
                id_d       = HALT_ID;
                id_valid_d = 1'b0;
                if (resume) begin
                    id_d    = BUBBLE_ID;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_RST;
            id_q            <= RESET_ID;
            id_valid_q      <= 1'b0;
            mode_q          <= 1'b1;
            count_q         <= '0;
            pending_flush_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            id_valid_q      <= id_valid_d;
            mode_q          <= mode_d;
            count_q         <= count_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    assign ID           = id_q;
    assign id_valid     = id_valid_q;
    assign MODE         = mode_q;
    assign halted       = (state_q == ST_HALT);
    assign issued_count = count_q;

endmodule
